// File: rtl/avmm_host_mem_responder_if.sv
// Split read/write Avalon-MM host memory channel: request/response bundle.
interface avmm_host_mem_responder_if #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 512,
   parameter int unsigned BURST_CNT_WIDTH = 3,
   parameter int unsigned USER_WIDTH      = 4
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic                       rd_read;
   logic [ADDR_WIDTH-1:0]      rd_address;
   logic [BURST_CNT_WIDTH-1:0] rd_burstcount;
   logic [USER_WIDTH-1:0]      rd_user;
   logic                       rd_waitrequest;
   logic                       rd_readdatavalid;
   logic [DATA_WIDTH-1:0]      rd_readdata;
   logic [USER_WIDTH-1:0]      rd_readresponseuser;

   logic                       wr_write;
   logic [ADDR_WIDTH-1:0]      wr_address;
   logic [BURST_CNT_WIDTH-1:0] wr_burstcount;
   logic [DATA_WIDTH-1:0]      wr_writedata;
   logic [BE_WIDTH-1:0]        wr_byteenable;
   logic [USER_WIDTH-1:0]      wr_user;
   logic                       wr_waitrequest;
   logic                       wr_writeresponsevalid;
   logic [USER_WIDTH-1:0]      wr_writeresponseuser;

   modport master (
      output rd_read, rd_address, rd_burstcount, rd_user,
      input  rd_waitrequest, rd_readdatavalid, rd_readdata, rd_readresponseuser,
      output wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable, wr_user,
      input  wr_waitrequest, wr_writeresponsevalid, wr_writeresponseuser
   );

   modport slave (
      input  rd_read, rd_address, rd_burstcount, rd_user,
      output rd_waitrequest, rd_readdatavalid, rd_readdata, rd_readresponseuser,
      input  wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable, wr_user,
      output wr_waitrequest, wr_writeresponsevalid, wr_writeresponseuser
   );
endinterface

// File: rtl/avmm_host_mem_responder.sv
// Avalon-MM responder for a split read/write host memory channel, backed by
// a line-addressed memory. Optional AVMM_HOST_MEM_RSP_RAND_WAIT_EN adds
// LFSR-driven random waitrequest insertion on both channels.
module avmm_host_mem_responder #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 512,
   parameter int unsigned BURST_CNT_WIDTH = 3,
   parameter int unsigned USER_WIDTH      = 4,
   parameter int unsigned MEM_DEPTH_LOG2  = 10,
   parameter int unsigned RD_LATENCY      = 4
) (
   input logic                 clk,
   input logic                 reset,
   avmm_host_mem_responder_if.slave bus
);
   localparam int unsigned DEPTH    = 1 << MEM_DEPTH_LOG2;
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   rd_state_t                  rd_state, rd_state_nxt;
   logic [ADDR_WIDTH-1:0]      rd_addr;
   logic [BURST_CNT_WIDTH-1:0] rd_beat, rd_last;
   logic [USER_WIDTH-1:0]      rd_user_q;
   logic                       rd_wait_c, rd_accept_c, rd_issue_c;

   logic [RD_LATENCY-1:0]                 rd_vld_pipe;
   logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] rd_data_pipe;
   logic [RD_LATENCY-1:0][USER_WIDTH-1:0] rd_user_pipe;

   logic                       wr_active;
   logic [ADDR_WIDTH-1:0]      wr_base;
   logic [BURST_CNT_WIDTH-1:0] wr_beat, wr_last;
   logic [USER_WIDTH-1:0]      wr_user_q, wr_rsp_user;
   logic                       wr_rsp_vld;
   logic                       wr_wait_c, wr_accept_c, wr_last_beat_c;
   logic [ADDR_WIDTH-1:0]      wr_cur_addr_c;
   logic [USER_WIDTH-1:0]      wr_user_c;
   logic [DATA_WIDTH-1:0]      wr_merge_c;

   logic rand_wait;

   // Burstcount 0 means a single beat; return index of the final beat.
   function automatic logic [BURST_CNT_WIDTH-1:0] last_idx(input logic [BURST_CNT_WIDTH-1:0] bc);
      return (bc == '0) ? '0 : bc - BURST_CNT_WIDTH'(1);
   endfunction

`ifdef AVMM_HOST_MEM_RSP_RAND_WAIT_EN
   logic [15:0] lfsr;

   // Free-running x^16+x^14+x^13+x^11+1 LFSR; bit 0 stalls both channels.
   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
   assign rand_wait = lfsr[0];
`else
   assign rand_wait = 1'b0;
`endif

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (reset) rd_state <= RD_IDLE;
      else       rd_state <= rd_state_nxt;
   end

   // Read FSM next state: one beat per BURST cycle, leave after the last.
   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE:  if (rd_accept_c) rd_state_nxt = RD_BURST;
         RD_BURST: if (rd_beat == rd_last) rd_state_nxt = RD_IDLE;
         default:  rd_state_nxt = RD_IDLE;
      endcase
   end

   // Read FSM outputs: stall while bursting, issue a beat every BURST cycle.
   always_comb begin
      rd_wait_c   = 1'b0;
      rd_issue_c  = 1'b0;
      rd_accept_c = 1'b0;
      if (!reset) begin
         rd_wait_c   = (rd_state == RD_BURST) || rand_wait;
         rd_issue_c  = (rd_state == RD_BURST);
         rd_accept_c = bus.rd_read && !rd_wait_c;
      end
   end

   // Read burst context: latch on accept, step the beat address while issuing.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr   <= '0;
         rd_beat   <= '0;
         rd_last   <= '0;
         rd_user_q <= '0;
      end else if (rd_accept_c) begin
         rd_addr   <= bus.rd_address;
         rd_beat   <= '0;
         rd_last   <= last_idx(bus.rd_burstcount);
         rd_user_q <= bus.rd_user;
      end else if (rd_issue_c) begin
         rd_addr   <= rd_addr + ADDR_WIDTH'(1);
         rd_beat   <= rd_beat + BURST_CNT_WIDTH'(1);
      end
   end

   // Fixed-latency read return pipeline; reset flushes in-flight beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld_pipe  <= '0;
         rd_data_pipe <= '0;
         rd_user_pipe <= '0;
      end else begin
         rd_vld_pipe[0]  <= rd_issue_c;
         rd_data_pipe[0] <= rd_issue_c ? mem[rd_addr[MEM_DEPTH_LOG2-1:0]] : '0;
         rd_user_pipe[0] <= rd_issue_c ? rd_user_q : '0;
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
            rd_data_pipe[i] <= rd_data_pipe[i-1];
            rd_user_pipe[i] <= rd_user_pipe[i-1];
         end
      end
   end

   assign bus.rd_waitrequest      = rd_wait_c;
   assign bus.rd_readdatavalid    = rd_vld_pipe[RD_LATENCY-1];
   assign bus.rd_readdata         = rd_data_pipe[RD_LATENCY-1];
   assign bus.rd_readresponseuser = rd_user_pipe[RD_LATENCY-1];

   // Write beat decode: first beat takes fields from the bus, later beats from the latched context.
   always_comb begin
      wr_wait_c      = !reset && rand_wait;
      wr_accept_c    = !reset && bus.wr_write && !wr_wait_c;
      wr_cur_addr_c  = wr_active ? wr_base + ADDR_WIDTH'(wr_beat) : bus.wr_address;
      wr_last_beat_c = wr_active ? (wr_beat == wr_last) : (last_idx(bus.wr_burstcount) == '0);
      wr_user_c      = wr_active ? wr_user_q : bus.wr_user;
      wr_merge_c     = mem[wr_cur_addr_c[MEM_DEPTH_LOG2-1:0]];
      for (int b = 0; b < int'(BE_WIDTH); b++) begin
         if (bus.wr_byteenable[b]) wr_merge_c[b*8 +: 8] = bus.wr_writedata[b*8 +: 8];
      end
   end

   // Backing store; not touched by reset, reads in the same cycle see old data.
   always_ff @(posedge clk) begin
      if (wr_accept_c) mem[wr_cur_addr_c[MEM_DEPTH_LOG2-1:0]] <= wr_merge_c;
   end

   // Write burst beat counter and one-cycle response after the final beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_active   <= 1'b0;
         wr_base     <= '0;
         wr_beat     <= '0;
         wr_last     <= '0;
         wr_user_q   <= '0;
         wr_rsp_vld  <= 1'b0;
         wr_rsp_user <= '0;
      end else begin
         wr_rsp_vld <= 1'b0;
         if (wr_accept_c) begin
            if (wr_last_beat_c) begin
               wr_active   <= 1'b0;
               wr_beat     <= '0;
               wr_rsp_vld  <= 1'b1;
               wr_rsp_user <= wr_user_c;
            end else begin
               wr_active <= 1'b1;
               wr_beat   <= wr_beat + BURST_CNT_WIDTH'(1);
               if (!wr_active) begin
                  wr_base   <= bus.wr_address;
                  wr_last   <= last_idx(bus.wr_burstcount);
                  wr_user_q <= bus.wr_user;
               end
            end
         end
      end
   end

   assign bus.wr_waitrequest        = wr_wait_c;
   assign bus.wr_writeresponsevalid = wr_rsp_vld;
   assign bus.wr_writeresponseuser  = wr_rsp_user;
endmodule

// File: tb/tb_avmm_host_mem_responder.sv
// Directed bench for avmm_host_mem_responder; random bursts when
// AVMM_HOST_MEM_RSP_RAND_WAIT_EN is defined.
`timescale 1ns/1ps
module tb_avmm_host_mem_responder;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 512;
   localparam int unsigned BW  = 3;
   localparam int unsigned UW  = 4;
   localparam int unsigned MDL = 10;
   localparam int unsigned LAT = 4;
   localparam int unsigned BEW = DW / 8;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   int   wr_rsp_seen = 0;
   int   wr_bursts = 0;
   logic [DW-1:0] wr_q[$];
   logic [DW-1:0] exp_q[$];

   avmm_host_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .USER_WIDTH(UW)) bus();

   avmm_host_mem_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
      .USER_WIDTH(UW), .MEM_DEPTH_LOG2(MDL), .RD_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!reset && bus.wr_writeresponsevalid) wr_rsp_seen++;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pat(input logic [31:0] k);
      return {16{32'hC0DE_0000 | k}};
   endfunction

   task automatic wr_burst(input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                           input logic [UW-1:0] user, input logic [BEW-1:0] be);
      int nb;
      int guard;
      nb = (bc == '0) ? 1 : int'(bc);
      for (int b = 0; b < nb; b++) begin
         bus.wr_write      = 1'b1;
         bus.wr_address    = addr;
         bus.wr_burstcount = bc;
         bus.wr_user       = user;
         bus.wr_byteenable = be;
         bus.wr_writedata  = wr_q.pop_front();
         if (b > 0) check("wr_rsp_mid_burst", DW'(bus.wr_writeresponsevalid), '0);
         guard = 0;
         while (bus.wr_waitrequest && guard < 64) begin step(); guard++; end
         check("wr_wait_timeout", DW'(bus.wr_waitrequest), '0);
         step();
      end
      bus.wr_write = 1'b0;
      check("wr_rsp_valid", DW'(bus.wr_writeresponsevalid), DW'(1));
      check("wr_rsp_user", DW'(bus.wr_writeresponseuser), DW'(user));
      wr_bursts++;
   endtask

   task automatic rd_burst(input logic [AW-1:0] addr, input logic [BW-1:0] bc, input logic [UW-1:0] user);
      int nb;
      int guard;
      bit vwin;
      nb = (bc == '0) ? 1 : int'(bc);
      bus.rd_read       = 1'b1;
      bus.rd_address    = addr;
      bus.rd_burstcount = bc;
      bus.rd_user       = user;
      guard = 0;
      while (bus.rd_waitrequest && guard < 64) begin step(); guard++; end
      check("rd_wait_timeout", DW'(bus.rd_waitrequest), '0);
      step();
      bus.rd_read = 1'b0;
      for (int k = 1; k <= nb + int'(LAT) + 1; k++) begin
         vwin = (k > int'(LAT)) && (k <= int'(LAT) + nb);
         if (k <= nb) check("rd_wait_in_burst", DW'(bus.rd_waitrequest), DW'(1));
`ifndef AVMM_HOST_MEM_RSP_RAND_WAIT_EN
         else check("rd_wait_idle", DW'(bus.rd_waitrequest), '0);
`endif
         check("rd_valid", DW'(bus.rd_readdatavalid), DW'(vwin));
         if (vwin) begin
            check("rd_data", bus.rd_readdata, exp_q.pop_front());
            check("rd_user", DW'(bus.rd_readresponseuser), DW'(user));
         end
         step();
      end
   endtask

`ifdef AVMM_HOST_MEM_RSP_RAND_WAIT_EN
   logic [DW-1:0] model [1 << MDL];
`endif

   initial begin
      bus.rd_read = 1'b0; bus.rd_address = '0; bus.rd_burstcount = '0; bus.rd_user = '0;
      bus.wr_write = 1'b0; bus.wr_address = '0; bus.wr_burstcount = '0; bus.wr_user = '0;
      bus.wr_writedata = '0; bus.wr_byteenable = '0;
      reset = 1'b1;
      repeat (3) step();
      check("rst_rd_wait", DW'(bus.rd_waitrequest), '0);
      check("rst_wr_wait", DW'(bus.wr_waitrequest), '0);
      check("rst_rd_valid", DW'(bus.rd_readdatavalid), '0);
      check("rst_wr_rsp", DW'(bus.wr_writeresponsevalid), '0);
      check("rst_rd_data", bus.rd_readdata, '0);
      check("rst_rd_user", DW'(bus.rd_readresponseuser), '0);
      check("rst_wr_user", DW'(bus.wr_writeresponseuser), '0);
      reset = 1'b0;
      step();

`ifndef AVMM_HOST_MEM_RSP_RAND_WAIT_EN
      // 4-beat write then read back
      for (int i = 0; i < 4; i++) wr_q.push_back(pat(i));
      wr_burst(32'h10, 3'd4, 4'h3, '1);
      for (int i = 0; i < 4; i++) exp_q.push_back(pat(i));
      rd_burst(32'h10, 3'd4, 4'h5);

      // single byte lane over a zeroed line
      wr_q.push_back('0);
      wr_burst(32'h20, 3'd1, 4'h1, '1);
      wr_q.push_back('1);
      wr_burst(32'h20, 3'd1, 4'h2, BEW'(1));
      exp_q.push_back(DW'(8'hFF));
      rd_burst(32'h20, 3'd1, 4'h6);

      // index wrap at top of memory, and full address wrap
      wr_q.push_back(pat(32'h30));
      wr_q.push_back(pat(32'h31));
      wr_burst(32'h3FF, 3'd2, 4'h4, '1);
      exp_q.push_back(pat(32'h30));
      exp_q.push_back(pat(32'h31));
      rd_burst(32'h3FF, 3'd2, 4'h7);
      exp_q.push_back(pat(32'h30));
      exp_q.push_back(pat(32'h31));
      rd_burst(32'hFFFF_FFFF, 3'd2, 4'h8);

      // burstcount 0 acts as a single beat
      wr_q.push_back(pat(32'h40));
      wr_burst(32'h40, 3'd0, 4'h9, '1);
      exp_q.push_back(pat(32'h40));
      rd_burst(32'h40, 3'd0, 4'hA);

      // read and write of the same line in the same cycle
      wr_q.push_back(pat(32'h50));
      wr_burst(32'h50, 3'd1, 4'h1, '1);
      exp_q.push_back(pat(32'h50));
      wr_q.push_back(pat(32'h51));
      fork
         rd_burst(32'h50, 3'd1, 4'hB);
         begin step(); wr_burst(32'h50, 3'd1, 4'hC, '1); end
      join
      exp_q.push_back(pat(32'h51));
      rd_burst(32'h50, 3'd1, 4'hD);

      // reset during beat 2 of a 4-beat read
      for (int i = 0; i < 4; i++) wr_q.push_back(pat(32'h60 + i));
      wr_burst(32'h60, 3'd4, 4'h1, '1);
      bus.rd_read = 1'b1; bus.rd_address = 32'h60; bus.rd_burstcount = 3'd4; bus.rd_user = 4'hE;
      check("abort_rd_accept", DW'(bus.rd_waitrequest), '0);
      step();
      bus.rd_read = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      check("abort_rd_wait_rst", DW'(bus.rd_waitrequest), '0);
      check("abort_rd_valid_rst", DW'(bus.rd_readdatavalid), '0);
      check("abort_rd_data_rst", bus.rd_readdata, '0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("abort_rd_valid", DW'(bus.rd_readdatavalid), '0);
         step();
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(pat(32'h60 + i));
      rd_burst(32'h60, 3'd4, 4'hF);

      // reset during a write burst, then a fresh single-beat write
      bus.wr_write = 1'b1; bus.wr_address = 32'h70; bus.wr_burstcount = 3'd4;
      bus.wr_user = 4'h2; bus.wr_byteenable = '1; bus.wr_writedata = pat(32'h70);
      step();
      bus.wr_writedata = pat(32'h71);
      step();
      bus.wr_write = 1'b0;
      reset = 1'b1;
      step();
      check("abort_wr_rsp_rst", DW'(bus.wr_writeresponsevalid), '0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("abort_wr_rsp", DW'(bus.wr_writeresponsevalid), '0);
         step();
      end
      wr_q.push_back(pat(32'h72));
      wr_burst(32'h74, 3'd1, 4'h7, '1);
      exp_q.push_back(pat(32'h70));
      exp_q.push_back(pat(32'h71));
      rd_burst(32'h70, 3'd2, 4'h3);
      exp_q.push_back(pat(32'h72));
      rd_burst(32'h74, 3'd1, 4'h4);
`else
      for (int i = 0; i < (1 << MDL); i++) begin
         model[i] = '0;
         wr_q.push_back('0);
         wr_burst(AW'(i), 3'd1, 4'h0, '1);
      end
      for (int it = 0; it < 1000; it++) begin
         logic [AW-1:0]  a;
         logic [AW-1:0]  la;
         logic [BW-1:0]  bc;
         logic [BEW-1:0] be;
         logic [DW-1:0]  d;
         int             nb;
         a  = AW'($urandom);
         bc = BW'($urandom_range(0, 7));
         be = {$urandom, $urandom};
         if (it % 4 == 0) be = '1;
         nb = (bc == '0) ? 1 : int'(bc);
         for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            wr_q.push_back(d);
            la = a + AW'(b);
            for (int y = 0; y < int'(BEW); y++)
               if (be[y]) model[la[MDL-1:0]][y*8 +: 8] = d[y*8 +: 8];
         end
         wr_burst(a, bc, UW'($urandom), be);
         for (int b = 0; b < nb; b++) begin
            la = a + AW'(b);
            exp_q.push_back(model[la[MDL-1:0]]);
         end
         rd_burst(a, bc, UW'($urandom));
      end
`endif

      step();
      check("wr_rsp_count", DW'(wr_rsp_seen), DW'(wr_bursts));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/avmm_host_mem_responder.md
AVMM_HOST_MEM_RESPONDER -- requirements
Module: avmm_host_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: line (not byte) address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512: data bus width, bits.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 3: burstcount width.
REQ-004 SHALL have parameter USER_WIDTH, default 4: request user field, echoed on responses.
REQ-005 SHALL have parameter MEM_DEPTH_LOG2, default 10: log2 of backing memory lines.
REQ-006 SHALL have parameter RD_LATENCY, default 4, range 1-16: cycles from read beat issue to readdatavalid.
REQ-007 SHALL have ports clk in 1 (sole clock, all logic on rising edge), then reset in 1 (synchronous, active-high).
REQ-008 SHALL have read ports: rd_read in 1; rd_address in ADDR_WIDTH; rd_burstcount in BURST_CNT_WIDTH; rd_user in USER_WIDTH; rd_waitrequest out 1; rd_readdatavalid out 1; rd_readdata out DATA_WIDTH; rd_readresponseuser out USER_WIDTH.
REQ-009 SHALL have write ports: wr_write in 1; wr_address in ADDR_WIDTH; wr_burstcount in BURST_CNT_WIDTH; wr_writedata in DATA_WIDTH; wr_byteenable in DATA_WIDTH/8; wr_user in USER_WIDTH; wr_waitrequest out 1; wr_writeresponsevalid out 1; wr_writeresponseuser out USER_WIDTH.

Function
REQ-010 SHALL be the Avalon-MM sink (responder) of a split read/write host memory channel, backed by a 2^MEM_DEPTH_LOG2 x DATA_WIDTH memory indexed by address[MEM_DEPTH_LOG2-1:0]; higher address bits ignored, index wraps modulo depth.
REQ-011 SHALL accept a request when its valid is high and its waitrequest was low in the same cycle.
REQ-012 Read FSM SHALL have states IDLE and BURST: IDLE accepts read, latches address/burstcount/user, goes to BURST; BURST issues one memory read per cycle at address+i, i=0..N-1; returns to IDLE the cycle after beat N-1 issues.
REQ-013 rd_waitrequest SHALL be high in BURST and in any cycle the read FSM cannot accept; low in IDLE.
REQ-014 Each issued read beat SHALL produce exactly one rd_readdatavalid pulse exactly RD_LATENCY cycles later, in order, carrying rd_readresponseuser equal to the burst's latched rd_user.
REQ-015 Write path SHALL count beats: first accepted beat latches address, burstcount, user; beat i writes line address+i, byte lanes gated by wr_byteenable.
REQ-016 wr_writeresponsevalid SHALL pulse exactly one cycle after the last beat of each write burst, with wr_writeresponseuser equal to the first beat's wr_user; one response per burst.
REQ-017 wr_waitrequest SHALL be low except as in REQ-024.
REQ-018 burstcount 0 SHALL be treated as 1.
REQ-019 Read and write of the same line in the same cycle SHALL return pre-write data (read-before-write).
REQ-020 Beat address arithmetic SHALL be ADDR_WIDTH-bit, wrapping without error.

Reset
REQ-021 While reset is high: rd_readdatavalid, wr_writeresponsevalid, rd_waitrequest, wr_waitrequest SHALL be 0; rd_readdata, rd_readresponseuser, wr_writeresponseuser SHALL be 0; FSM IDLE; beat counters 0.
REQ-022 Reset mid-burst SHALL abort the burst and flush the latency pipeline; no readdatavalid or writeresponsevalid SHALL appear in the cycles after reset deasserts for requests accepted before reset.
REQ-023 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-024 With AVMM_HOST_MEM_RSP_RAND_WAIT_EN defined, a 16-bit LFSR (seed 16'hACE1 on reset, x^16+x^14+x^13+x^11+1, advances every cycle) SHALL additionally force rd_waitrequest and wr_waitrequest high whenever LFSR bit 0 is 1; undefined, no LFSR is built and waitrequest follows REQ-013/REQ-017 only.

Verification
REQ-025 Write burst addr 0x10, burstcount 4, data D0-D3, byteenable all 1s, user 0x3 -> one wr_writeresponsevalid one cycle after beat 3, user 0x3.
REQ-026 Then read addr 0x10 burstcount 4 user 0x5 -> 4 readdatavalid beats D0-D3, first exactly RD_LATENCY cycles after the first read beat issues, user 0x5, rd_waitrequest high 4 cycles.
REQ-027 Write addr 0x20 byteenable 0x1 data all-ones over all-zero line -> read returns 0x...00FF.
REQ-028 Read burstcount 2 at address 2^MEM_DEPTH_LOG2-1 -> beats from index 1023 then 0.
REQ-029 Reset asserted during beat 2 of 4-beat read -> no readdatavalid after reset; next read returns correct data.
REQ-030 With AVMM_HOST_MEM_RSP_RAND_WAIT_EN, 1000 random bursts -> every readback matches, response count equals burst count.
